if_align_buffer: RTL

- Fetch and align stage directly upstream of the decoder/ControlUnit.
- Issues word-aligned 32-bit fetches to instruction memory and buffers the returned halfwords.
- Aligns mixed 16-bit (RVC) and 32-bit instructions, including ones straddling a word boundary.
- Presents one instruction per handshake with its PC, a compressed flag and the 5-bit opcode field; handles branch/jump redirects.

---
 rtl/if_align_buffer.sv | 108 ++++++++++
 1 files changed

// File: rtl/if_align_buffer.sv
// ============================================================================
// if_align_buffer : fetch + RVC/32-bit instruction alignment ahead of decode
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module if_align_buffer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_is_c,
  output logic [4:0]  opcode,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  logic [15:0] hbuf [4];
  logic [15:0] nbuf [4];
  logic [2:0]  count;
  logic        outstanding;
  logic        kill;
  logic        skip;
  logic [31:0] fetch_addr;
  logic [31:0] head_pc;

  logic        is_c;
  logic        fire;
  logic        accept;
  logic [2:0]  pop_n;
  logic [2:0]  push_n;
  logic [2:0]  base;
  logic [15:0] push_lo;

  assign is_c       = (hbuf[0][1:0] != 2'b11);
  assign inst_valid = ((count >= 3'd1) && is_c) || ((count >= 3'd2) && !is_c);
  assign inst       = is_c ? {16'h0000, hbuf[0]} : {hbuf[1], hbuf[0]};
  assign inst_is_c  = is_c;
  assign opcode     = inst[6:2];
  assign inst_pc    = head_pc;
  assign imem_addr  = fetch_addr;
  // Requests only when two free entries are guaranteed, so a push never overflows.
  assign imem_req   = rst_n && !outstanding && (count <= 3'd2) && !redirect_valid;

  assign fire    = inst_valid && inst_ready;
  assign pop_n   = fire ? (is_c ? 3'd1 : 3'd2) : 3'd0;
  assign accept  = imem_valid && outstanding && !kill;
  assign push_n  = accept ? (skip ? 3'd1 : 3'd2) : 3'd0;
  assign push_lo = skip ? imem_rdata[31:16] : imem_rdata[15:0];
  assign base    = count - pop_n;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      nbuf[i] = hbuf[i];
      if ((3'(i) + pop_n) < 3'd4)
        nbuf[i] = hbuf[2'(3'(i) + pop_n)];
      if ((push_n != 3'd0) && (3'(i) == base))
        nbuf[i] = push_lo;
      if ((push_n == 3'd2) && (3'(i) == base + 3'd1))
        nbuf[i] = imem_rdata[31:16];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) hbuf[i] <= 16'h0000;
      count       <= 3'd0;
      outstanding <= 1'b0;
      kill        <= 1'b0;
      skip        <= RESET_PC[1];
      fetch_addr  <= {RESET_PC[31:2], 2'b00};
      head_pc     <= {RESET_PC[31:1], 1'b0};
    end else begin
      hbuf <= nbuf;
      if (redirect_valid) begin
        // A response landing this cycle retires the fetch, so nothing is left to kill.
        count       <= 3'd0;
        head_pc     <= {redirect_pc[31:1], 1'b0};
        fetch_addr  <= {redirect_pc[31:2], 2'b00};
        skip        <= redirect_pc[1];
        kill        <= outstanding && !imem_valid;
        outstanding <= outstanding && !imem_valid;
      end else begin
        count   <= count - pop_n + push_n;
        head_pc <= head_pc + {28'h0, pop_n, 1'b0};
        if (imem_req) begin
          fetch_addr  <= fetch_addr + 32'd4;
          outstanding <= 1'b1;
        end else if (imem_valid && outstanding) begin
          outstanding <= 1'b0;
          if (kill) kill <= 1'b0;
          else if (skip) skip <= 1'b0;
        end
      end
    end
  end

endmodule

`default_nettype wire
